mux_scan_ctrl: RTL and testbench

Sequential channel scanner that sits directly upstream of the 8-to-1 multiplexer. It drives the mux select lines `s2..s0` and samples the mux output `y` back. On a start request it walks the enabled channels in ascending order and holds each select for a programmable dwell time. At the end of each dwell it captures `y` into a per-channel result bit, then reports completion with a one-cycle `done` pulse.

---
 rtl/mux_scan_pkg.sv | 13 +
 rtl/mux_scan_next.sv | 25 ++
 rtl/mux_scan_ctrl.sv | 124 ++++++++++++
 tb/tb_mux_scan_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 8-channel mux scanner.
package mux_scan_pkg;

  localparam int unsigned N_CH = 8;
  localparam int unsigned CH_W = 3;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StDone   = 2'd2
  } state_e;

endpackage

// File: rtl/mux_scan_next.sv
// Combinational channel search: the lowest set mask bit when i_first is high,
// otherwise the lowest set bit strictly above i_cur.
import mux_scan_pkg::*;

module mux_scan_next (
  input  logic [N_CH-1:0] i_mask,
  input  logic [CH_W-1:0] i_cur,
  input  logic            i_first,
  output logic [CH_W-1:0] o_next,
  output logic            o_found
);

  // Walk downwards so the lowest qualifying bit is the last one written.
  always_comb begin
    o_next  = '0;
    o_found = 1'b0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (i_mask[k] && (i_first || (k > int'(i_cur)))) begin
        o_next  = CH_W'(k);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Sequential scanner driving 8-to-1 mux selects and capturing the mux output
// per enabled channel. Optional continuous rescan is built when
// MUX_SCAN_CONT_EN is defined (adds the cont input).
import mux_scan_pkg::*;

module mux_scan_ctrl #(
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_CH-1:0]    ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               y,
`ifdef MUX_SCAN_CONT_EN
  input  logic               cont,
`endif
  output logic               s0,
  output logic               s1,
  output logic               s2,
  output logic               busy,
  output logic               done,
  output logic [N_CH-1:0]    data
);

  state_e             r_state, w_state_d;
  logic [N_CH-1:0]    r_mask, w_mask_d;
  logic [DWELL_W-1:0] r_dwell, w_dwell_d;
  logic [DWELL_W-1:0] r_cnt, w_cnt_d;
  logic [CH_W-1:0]    r_ch, w_ch_d;
  logic [N_CH-1:0]    r_data, w_data_d;

  logic               w_first;
  logic [N_CH-1:0]    w_srch_mask;
  logic [CH_W-1:0]    w_next;
  logic               w_found;
  logic               w_load;

  // Outside SETTLE the search looks at the live mask for a fresh scan.
  assign w_first     = (r_state != StSettle);
  assign w_srch_mask = w_first ? ch_mask : r_mask;

  mux_scan_next u_next (
    .i_mask  (w_srch_mask),
    .i_cur   (r_ch),
    .i_first (w_first),
    .o_next  (w_next),
    .o_found (w_found)
  );

`ifdef MUX_SCAN_CONT_EN
  assign w_load = ((r_state == StIdle) && start) || ((r_state == StDone) && cont);
`else
  assign w_load = (r_state == StIdle) && start;
`endif

  // Next-state logic: dwell countdown, sample/advance, and scan (re)load.
  always_comb begin
    w_state_d = r_state;
    w_mask_d  = r_mask;
    w_dwell_d = r_dwell;
    w_cnt_d   = r_cnt;
    w_ch_d    = r_ch;
    w_data_d  = r_data;

    unique case (r_state)
      StIdle: ;
      StSettle: begin
        if (r_cnt != '0) begin
          w_cnt_d = r_cnt - DWELL_W'(1);
        end else begin
          w_data_d[r_ch] = y;
          if (w_found) begin
            w_ch_d  = w_next;
            w_cnt_d = r_dwell;
          end else begin
            w_state_d = StDone;
          end
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase

    // A zero mask skips SETTLE entirely; the select keeps its last channel.
    if (w_load) begin
      w_mask_d  = ch_mask;
      w_dwell_d = dwell;
      w_data_d  = '0;
      if (w_found) begin
        w_ch_d    = w_next;
        w_cnt_d   = dwell;
        w_state_d = StSettle;
      end else begin
        w_state_d = StDone;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_mask  <= '0;
      r_dwell <= '0;
      r_cnt   <= '0;
      r_ch    <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_d;
      r_mask  <= w_mask_d;
      r_dwell <= w_dwell_d;
      r_cnt   <= w_cnt_d;
      r_ch    <= w_ch_d;
      r_data  <= w_data_d;
    end
  end

  assign {s2, s1, s0} = r_ch;
  assign busy         = (r_state == StSettle);
  assign done         = (r_state == StDone);
  assign data         = r_data;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with a behavioural 8-to-1 mux on y.
module tb_mux_scan_ctrl;

  typedef struct {
    logic [7:0] data;
    int         done_k;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] ch_mask;
  logic [3:0] dwell;
  logic       y;
  logic       cont;
  logic       s0, s1, s2;
  logic       busy;
  logic       done;
  logic [7:0] data;

  // Channel k input of the external mux; {i0..i7} = 8'b10101010.
  logic [7:0] mux_bits;
  logic [2:0] last_ch;

  int checks;
  int errors;

  exp_t       exp_q[$];
  logic [2:0] sel_q[$];

  assign y = mux_bits[{s2, s1, s0}];

  mux_scan_ctrl #(
    .DWELL_W (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .ch_mask (ch_mask),
    .dwell   (dwell),
    .y       (y),
`ifdef MUX_SCAN_CONT_EN
    .cont    (cont),
`endif
    .s0      (s0),
    .s1      (s1),
    .s2      (s2),
    .busy    (busy),
    .done    (done),
    .data    (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one scan; k counts negedges after the accepting edge E0, so k is the
  // cycle beginning at E0+k. abort_k >= 0 pulls reset in that cycle.
  task automatic scan(input string tag, input logic [7:0] m, input logic [3:0] d,
                      input int abort_k, input bit perturb);
    exp_t e;
    exp_t got;
    int   n;
    bit   fin;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      if (m[c]) begin
        n++;
        for (int r = 0; r <= int'(d); r++) sel_q.push_back(3'(c));
        last_ch = 3'(c);
      end
    end
    e.data   = mux_bits & m;
    e.done_k = n * (int'(d) + 1);
    exp_q.push_back(e);

    @(negedge clk);
    start   = 1'b1;
    ch_mask = m;
    dwell   = d;
    @(negedge clk);
    start = 1'b0;
    fin   = 1'b0;
    for (int k = 0; k < 300 && !fin; k++) begin
      if (k == abort_k) begin
        rst_n = 1'b0;
        #1;
        check({tag, " rst sel"}, 32'({s2, s1, s0}), 32'd0);
        check({tag, " rst busy"}, 32'(busy), 32'd0);
        check({tag, " rst done"}, 32'(done), 32'd0);
        check({tag, " rst data"}, 32'(data), 32'd0);
        sel_q.delete();
        exp_q.delete();
        last_ch = 3'd0;
        fin     = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        if (busy) begin
          if (sel_q.size() > 0) check({tag, " sel"}, 32'({s2, s1, s0}), 32'(sel_q.pop_front()));
          else check({tag, " extra busy"}, 32'(busy), 32'd0);
        end
        if (done) begin
          got = exp_q.pop_front();
          check({tag, " done cycle"}, k, got.done_k);
          check({tag, " data"}, 32'(data), 32'(got.data));
          check({tag, " sel left"}, sel_q.size(), 0);
          fin = 1'b1;
          @(negedge clk);
          check({tag, " done width"}, 32'(done), 32'd0);
          check({tag, " idle busy"}, 32'(busy), 32'd0);
          check({tag, " hold data"}, 32'(data), 32'(got.data));
          check({tag, " hold sel"}, 32'({s2, s1, s0}), 32'(last_ch));
        end else begin
          if (perturb && k == 1) begin
            start   = 1'b1;
            ch_mask = ~m;
            dwell   = 4'hF;
          end
          if (perturb && k == 2) begin
            start   = 1'b0;
            ch_mask = m;
            dwell   = d;
          end
          @(negedge clk);
        end
      end
    end
    if (!fin) check({tag, " timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    ch_mask  = 8'h00;
    dwell    = 4'd0;
    cont     = 1'b0;
    mux_bits = 8'b0101_0101;
    last_ch  = 3'd0;

    repeat (3) @(negedge clk);
    check("reset sel", 32'({s2, s1, s0}), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset data", 32'(data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    scan("full d0", 8'hFF, 4'd0, -1, 1'b0);
    scan("empty mask", 8'h00, 4'd0, -1, 1'b0);
    scan("sparse d2", 8'b1001_0010, 4'd2, -1, 1'b0);
    scan("restart ignored", 8'b0110_0100, 4'd1, -1, 1'b1);
    scan("abort", 8'hFF, 4'd0, 3, 1'b0);
    scan("after abort", 8'h81, 4'd3, -1, 1'b0);
    scan("back to back", 8'h0F, 4'd0, -1, 1'b0);

`ifdef MUX_SCAN_CONT_EN
    // Continuous mode: done every 3 cycles at E0+2, E0+5, E0+8; cont drops in
    // the last DONE cycle so the block returns to IDLE.
    begin
      int pulses;
      pulses = 0;
      @(negedge clk);
      cont    = 1'b1;
      start   = 1'b1;
      ch_mask = 8'h03;
      dwell   = 4'd0;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 10; k++) begin
        check("cont done", 32'(done), 32'((k % 3) == 2 && k < 9));
        if (done) begin
          pulses++;
          check("cont data", 32'(data), 32'(mux_bits & 8'h03));
          if (pulses == 3) cont = 1'b0;
        end
        @(negedge clk);
      end
      check("cont idle busy", 32'(busy), 32'd0);
      check("cont idle done", 32'(done), 32'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
